alu_arbiter: RTL

Shares one combinational ALU between two requesters: req0 is the execute stage and req1 is the branch/address unit. The block arbitrates round-robin and drives the ALU operands and opcode from the granted request. It captures the ALU result and branch flag into a per-requester response register. Each request and response side uses a valid/ready handshake. It sits between the issue logic and the single ALU instance in the core.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_arbiter_if.sv | 58 +++++
 rtl/alu_rsp_slot.sv | 42 ++++
 rtl/alu_arbiter.sv | 84 ++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths, opcode encodings and the opcode legality check for the
// ALU arbiter slice.
package alu_pkg;

    localparam int XLEN = 32;
    localparam int OPW  = 5;

    localparam logic [OPW-1:0] OP_ADD  = 5'b00000;
    localparam logic [OPW-1:0] OP_SLL  = 5'b00001;
    localparam logic [OPW-1:0] OP_SLT  = 5'b00010;
    localparam logic [OPW-1:0] OP_SLTU = 5'b00011;
    localparam logic [OPW-1:0] OP_XOR  = 5'b00100;
    localparam logic [OPW-1:0] OP_SRL  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_AND  = 5'b00111;
    localparam logic [OPW-1:0] OP_SUB  = 5'b01000;
    localparam logic [OPW-1:0] OP_SRA  = 5'b01101;
    localparam logic [OPW-1:0] OP_BEQ  = 5'b10000;
    localparam logic [OPW-1:0] OP_BNE  = 5'b10001;
    localparam logic [OPW-1:0] OP_BLT  = 5'b10100;
    localparam logic [OPW-1:0] OP_BGE  = 5'b10101;
    localparam logic [OPW-1:0] OP_BLTU = 5'b10110;
    localparam logic [OPW-1:0] OP_BGEU = 5'b10111;
    localparam logic [OPW-1:0] OP_JAL  = 5'b11111;

    function automatic logic op_legal(input logic [OPW-1:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND,
            OP_SUB, OP_SRA, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
            OP_JAL:  legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signals of the ALU arbiter. The slave
// modport is the arbiter; the master modport is its surroundings.
interface alu_arbiter_if;
    import alu_pkg::*;

    logic            req0_valid_i;
    logic            req0_ready_o;
    logic [XLEN-1:0] req0_a_i;
    logic [XLEN-1:0] req0_b_i;
    logic [OPW-1:0]  req0_op_i;

    logic            req1_valid_i;
    logic            req1_ready_o;
    logic [XLEN-1:0] req1_a_i;
    logic [XLEN-1:0] req1_b_i;
    logic [OPW-1:0]  req1_op_i;

    logic            rsp0_valid_o;
    logic            rsp0_ready_i;
    logic [XLEN-1:0] rsp0_d_o;
    logic            rsp0_branch_o;
    logic            rsp0_err_o;

    logic            rsp1_valid_o;
    logic            rsp1_ready_i;
    logic [XLEN-1:0] rsp1_d_o;
    logic            rsp1_branch_o;
    logic            rsp1_err_o;

    logic [XLEN-1:0] alu_a_o;
    logic [XLEN-1:0] alu_b_o;
    logic [OPW-1:0]  alu_op_o;
    logic [XLEN-1:0] alu_d_i;
    logic            alu_branch_i;

    modport slave (
        input  req0_valid_i, req0_a_i, req0_b_i, req0_op_i,
        input  req1_valid_i, req1_a_i, req1_b_i, req1_op_i,
        output req0_ready_o, req1_ready_o,
        output rsp0_valid_o, rsp0_d_o, rsp0_branch_o, rsp0_err_o,
        output rsp1_valid_o, rsp1_d_o, rsp1_branch_o, rsp1_err_o,
        input  rsp0_ready_i, rsp1_ready_i,
        output alu_a_o, alu_b_o, alu_op_o,
        input  alu_d_i, alu_branch_i
    );

    modport master (
        output req0_valid_i, req0_a_i, req0_b_i, req0_op_i,
        output req1_valid_i, req1_a_i, req1_b_i, req1_op_i,
        input  req0_ready_o, req1_ready_o,
        input  rsp0_valid_o, rsp0_d_o, rsp0_branch_o, rsp0_err_o,
        input  rsp1_valid_o, rsp1_d_o, rsp1_branch_o, rsp1_err_o,
        output rsp0_ready_i, rsp1_ready_i,
        input  alu_a_o, alu_b_o, alu_op_o,
        output alu_d_i, alu_branch_i
    );

endinterface

// File: rtl/alu_rsp_slot.sv
// One-entry response holding register: captures an ALU result on a grant,
// flags illegal opcodes, and supports pop-and-refill in the same cycle.
module alu_rsp_slot
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [OPW-1:0]  op,
    input  logic [XLEN-1:0] alu_d,
    input  logic            alu_branch,
    input  logic            pop_ready,
    output logic            valid,
    output logic [XLEN-1:0] d,
    output logic            branch,
    output logic            err,
    output logic            can_accept
);

    logic legal;

    assign legal      = op_legal(op);
    assign can_accept = !valid || pop_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= 1'b0;
            d      <= '0;
            branch <= 1'b0;
            err    <= 1'b0;
        end else if (load) begin
            // an illegal opcode never exposes whatever the ALU produced
            valid  <= 1'b1;
            d      <= legal ? alu_d : '0;
            branch <= legal & alu_branch;
            err    <= !legal;
        end else if (valid && pop_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between the execute stage
// (req0) and the branch/address unit (req1), with a response slot per side.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    alu_arbiter_if.slave  bus
);

    logic last_gnt;
    logic can0;
    logic can1;
    logic elig0;
    logic elig1;
    logic gnt0;
    logic gnt1;

    assign elig0 = bus.req0_valid_i && can0;
    assign elig1 = bus.req1_valid_i && can1;

    // on contention the requester that did not win last time goes first
    assign gnt0 = elig0 && (!elig1 || last_gnt);
    assign gnt1 = elig1 && (!elig0 || !last_gnt);

    assign bus.req0_ready_o = gnt0;
    assign bus.req1_ready_o = gnt1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_gnt <= 1'b1;
        end else if (gnt0) begin
            last_gnt <= 1'b0;
        end else if (gnt1) begin
            last_gnt <= 1'b1;
        end
    end

    always_comb begin
        bus.alu_a_o  = '0;
        bus.alu_b_o  = '0;
        bus.alu_op_o = OP_ADD;
        if (gnt0) begin
            bus.alu_a_o  = bus.req0_a_i;
            bus.alu_b_o  = bus.req0_b_i;
            bus.alu_op_o = bus.req0_op_i;
        end else if (gnt1) begin
            bus.alu_a_o  = bus.req1_a_i;
            bus.alu_b_o  = bus.req1_b_i;
            bus.alu_op_o = bus.req1_op_i;
        end
    end

    alu_rsp_slot u_slot0 (
        .clk        (clk_i),
        .rst        (rst_i),
        .load       (gnt0),
        .op         (bus.alu_op_o),
        .alu_d      (bus.alu_d_i),
        .alu_branch (bus.alu_branch_i),
        .pop_ready  (bus.rsp0_ready_i),
        .valid      (bus.rsp0_valid_o),
        .d          (bus.rsp0_d_o),
        .branch     (bus.rsp0_branch_o),
        .err        (bus.rsp0_err_o),
        .can_accept (can0)
    );

    alu_rsp_slot u_slot1 (
        .clk        (clk_i),
        .rst        (rst_i),
        .load       (gnt1),
        .op         (bus.alu_op_o),
        .alu_d      (bus.alu_d_i),
        .alu_branch (bus.alu_branch_i),
        .pop_ready  (bus.rsp1_ready_i),
        .valid      (bus.rsp1_valid_o),
        .d          (bus.rsp1_d_o),
        .branch     (bus.rsp1_branch_o),
        .err        (bus.rsp1_err_o),
        .can_accept (can1)
    );

endmodule
